line_mem_arbiter: RTL and testbench

- Sits directly upstream of the physical memory model. Arbitrates 256-bit line requests from the I-cache (read-only) and D-cache (read/write) onto the single physical memory port.
- Latches the winning request, holds the memory strobes until memory responds, and steers the response back to the granted cache.
- Guarantees the memory strobes drop for at least one cycle between transactions.

---
 rtl/line_mem_arbiter_if.sv | 42 ++++
 rtl/line_mem_arbiter.sv | 102 ++++++++++
 tb/tb_line_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_mem_arbiter_if.sv
// line_mem_arbiter_if: cache-side and memory-side line bus of the arbiter.
// slave  = arbiter view (takes cache requests, drives the memory strobes).
// master = environment view (caches and physical memory model).
interface line_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 256
);
  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic              icache_resp;
  logic [LINE_W-1:0] icache_rdata;

  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [LINE_W-1:0] dcache_wdata;
  logic              dcache_resp;
  logic [LINE_W-1:0] dcache_rdata;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;

  modport slave (
    input  icache_read, icache_address,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  pmem_resp, pmem_rdata,
    output icache_resp, icache_rdata, dcache_resp, dcache_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output icache_read, icache_address,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    output pmem_resp, pmem_rdata,
    input  icache_resp, icache_rdata, dcache_resp, dcache_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: shares one physical line-memory port between the
// I-cache (read only) and the D-cache (read/write). The winning request is
// latched, strobes are held until pmem_resp, and one idle cycle separates
// consecutive transactions.
// Build option: LINE_MEM_ARBITER_RR_EN selects round-robin on ties;
// otherwise the D-cache always wins.
module line_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 256
) (
  input logic              clk,
  input logic              rst,
  line_mem_arbiter_if.slave bus
);
`ifdef LINE_MEM_ARBITER_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;
  typedef enum logic {GNT_ICACHE, GNT_DCACHE} grant_t;

  state_t            state_q, state_d;
  grant_t            grant_q, last_grant_q, win;
  logic              rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              i_req, d_req, take, done;

  // Pick a winner among the requests presented this cycle
  always_comb begin
    i_req = bus.icache_read;
    d_req = bus.dcache_read | bus.dcache_write;
    win   = d_req ? GNT_DCACHE : GNT_ICACHE;
    if (RR_EN && i_req && d_req)
      win = (last_grant_q == GNT_DCACHE) ? GNT_ICACHE : GNT_DCACHE;
  end

  // Next state; RECOVER never arbitrates so a request held across the
  // response edge cannot be served twice
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    done    = (state_q == BUSY) && bus.pmem_resp;
    case (state_q)
      IDLE:    if (i_req || d_req) begin
                 state_d = BUSY;
                 take    = 1'b1;
               end
      BUSY:    if (bus.pmem_resp) state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latch the winning transaction and hold the strobes until memory answers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      grant_q      <= GNT_ICACHE;
      last_grant_q <= GNT_DCACHE;
    end else if (take) begin
      grant_q <= win;
      if (win == GNT_DCACHE) begin
        // a write wins over a simultaneous read from the same client
        wr_q    <= bus.dcache_write;
        rd_q    <= ~bus.dcache_write;
        addr_q  <= bus.dcache_address;
        wdata_q <= bus.dcache_wdata;
      end else begin
        wr_q    <= 1'b0;
        rd_q    <= 1'b1;
        addr_q  <= bus.icache_address;
      end
    end else if (done) begin
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      last_grant_q <= grant_q;
    end
  end

  assign bus.pmem_read    = rd_q;
  assign bus.pmem_write   = wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  // Read data is broadcast; only the granted client's resp qualifies it
  assign bus.icache_resp  = done && (grant_q == GNT_ICACHE);
  assign bus.dcache_resp  = done && (grant_q == GNT_DCACHE);
  assign bus.icache_rdata = bus.pmem_rdata;
  assign bus.dcache_rdata = bus.pmem_rdata;
endmodule

// File: tb/tb_line_mem_arbiter.sv
// tb_line_mem_arbiter: directed scenarios for line_mem_arbiter with a
// transaction-level model checked every cycle plus literal expectations.
module tb_line_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 256;
  typedef logic [LINE_W-1:0] line_t;
  typedef logic [ADDR_W-1:0] addr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  line_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus();
  line_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // memory model
  line_t mem [addr_t];
  int    mem_lat = 4;
  int    mem_cnt;
  logic  mem_resp;
  logic  stray_resp = 1'b0;
  line_t mem_rdata;
  assign bus.pmem_resp  = mem_resp | stray_resp;
  assign bus.pmem_rdata = mem_rdata;

  // observed client responses
  int    i_cnt = 0, d_cnt = 0;
  line_t i_rdata, d_rdata;
  int    order_q[$];
  logic  prev_resp = 1'b0;

  // transaction-level model: one transaction in flight, then a one-cycle gap
  bit    m_active = 0, m_gap = 0, m_wr = 0, m_cli = 0, m_last = 1;
  addr_t m_addr;
  line_t m_wdata;

  line_t LA5, LDB, LI, LD, LX;

  task automatic chk(input string nm, input line_t act, input line_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, line_t'(act), line_t'(exp));
  endtask

  function automatic bit pick_dcache(input bit ireq, input bit dreq, input bit last_was_d);
    bit p;
    p = dreq;
`ifdef LINE_MEM_ARBITER_RR_EN
    if (ireq && dreq) p = !last_was_d;
`else
    if (ireq && last_was_d) p = dreq;
`endif
    return p;
  endfunction

  // model update
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 0; m_gap <= 0; m_last <= 1;
    end else if (m_active) begin
      if (bus.pmem_resp) begin m_active <= 0; m_gap <= 1; m_last <= m_cli; end
    end else if (m_gap) begin
      m_gap <= 0;
    end else if (bus.icache_read || bus.dcache_read || bus.dcache_write) begin
      m_active <= 1;
      if (pick_dcache(bus.icache_read, bus.dcache_read || bus.dcache_write, m_last)) begin
        m_cli <= 1; m_wr <= bus.dcache_write;
        m_addr <= bus.dcache_address; m_wdata <= bus.dcache_wdata;
      end else begin
        m_cli <= 0; m_wr <= 0; m_addr <= bus.icache_address;
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (rst) begin
      chk1("rst_pmem_read", bus.pmem_read, 1'b0);
      chk1("rst_pmem_write", bus.pmem_write, 1'b0);
      chk1("rst_icache_resp", bus.icache_resp, 1'b0);
      chk1("rst_dcache_resp", bus.dcache_resp, 1'b0);
      prev_resp = 1'b0;
    end else begin
      chk1("pmem_read", bus.pmem_read, m_active && !m_wr);
      chk1("pmem_write", bus.pmem_write, m_active && m_wr);
      if (m_active) begin
        chk("pmem_address", line_t'(bus.pmem_address), line_t'(m_addr));
        if (m_wr) chk("pmem_wdata", bus.pmem_wdata, m_wdata);
      end
      chk1("icache_resp", bus.icache_resp, m_active && bus.pmem_resp && !m_cli);
      chk1("dcache_resp", bus.dcache_resp, m_active && bus.pmem_resp && m_cli);
      chk("icache_rdata", bus.icache_rdata, bus.pmem_rdata);
      chk("dcache_rdata", bus.dcache_rdata, bus.pmem_rdata);
      if (prev_resp) chk("recover_gap", line_t'({bus.pmem_read, bus.pmem_write}), '0);
      prev_resp = bus.icache_resp | bus.dcache_resp;
      if (bus.icache_resp) begin i_cnt++; i_rdata = bus.icache_rdata; order_q.push_back(0); end
      if (bus.dcache_resp) begin d_cnt++; d_rdata = bus.dcache_rdata; order_q.push_back(1); end
    end
  end

  // memory responder: pulses pmem_resp after mem_lat strobe cycles
  initial begin
    mem_resp = 1'b0; mem_cnt = 0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_resp) mem_resp = 1'b0;
      else if (rst) mem_cnt = 0;
      else if (bus.pmem_read || bus.pmem_write) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          mem_cnt = 0;
          mem_resp = 1'b1;
          if (bus.pmem_write) mem[bus.pmem_address] = bus.pmem_wdata;
          else mem_rdata = mem.exists(bus.pmem_address) ? mem[bus.pmem_address] : '0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic int cnt_of(input int which);
    return (which == 0) ? i_cnt : (which == 1) ? d_cnt : i_cnt + d_cnt;
  endfunction

  task automatic wait_resp(input int which, input int target, input int budget, input string nm);
    int n = 0;
    while (cnt_of(which) < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(nm, line_t'(cnt_of(which)), line_t'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ib, db, first, second;
    LA5 = {32{8'hA5}};
    LDB = {8{32'hDEADBEEF}};
    LI  = {8{32'h1111_0100}};
    LD  = {8{32'h2222_0200}};
    LX  = {8{32'h3333_0040}};
    bus.icache_read = 0; bus.icache_address = '0;
    bus.dcache_read = 0; bus.dcache_write = 0;
    bus.dcache_address = '0; bus.dcache_wdata = '0;
    mem[16'h1240] = LA5; mem[16'h0100] = LI; mem[16'h0200] = LD; mem[16'h0040] = LX;

    // reset state
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("reset_pmem_address", line_t'(bus.pmem_address), '0);
    chk("reset_pmem_wdata", bus.pmem_wdata, '0);
    step();
    rst = 1'b0;
    step();

    // I-cache read, 250 ns memory latency
    mem_lat = 25; ib = i_cnt; db = d_cnt;
    bus.icache_read = 1; bus.icache_address = 16'h1240;
    @(negedge clk);
    chk1("s1_no_strobe_in_arb_cycle", bus.pmem_read, 1'b0);
    @(negedge clk);
    chk1("s1_pmem_read", bus.pmem_read, 1'b1);
    chk("s1_pmem_address", line_t'(bus.pmem_address), line_t'(16'h1240));
    wait_resp(0, ib + 1, 40, "s1_icache_resp_seen");
    chk("s1_icache_rdata", i_rdata, LA5);
    step(); bus.icache_read = 0;
    repeat (3) step();
    chk("s1_icache_resp_once", line_t'(i_cnt - ib), line_t'(1));
    chk("s1_no_dcache_resp", line_t'(d_cnt - db), '0);

    // D-cache write (read also high: write wins), then read back
    mem_lat = 3; db = d_cnt;
    bus.dcache_write = 1; bus.dcache_read = 1;
    bus.dcache_address = 16'h0020; bus.dcache_wdata = LDB;
    @(negedge clk); @(negedge clk);
    chk1("s2_pmem_write", bus.pmem_write, 1'b1);
    chk1("s2_pmem_read_low", bus.pmem_read, 1'b0);
    chk("s2_pmem_wdata", bus.pmem_wdata, LDB);
    wait_resp(1, db + 1, 20, "s2_write_resp_seen");
    step(); bus.dcache_write = 0;
    @(negedge clk);
    chk("s2_strobe_gap", line_t'({bus.pmem_read, bus.pmem_write}), '0);
    wait_resp(1, db + 2, 20, "s2_read_resp_seen");
    chk("s2_readback", d_rdata, LDB);
    step(); bus.dcache_read = 0;
    repeat (2) step();

    // both request in the same cycle, right after reset
    do_reset();
    mem_lat = 4; ib = i_cnt; db = d_cnt; order_q.delete();
    bus.icache_read = 1; bus.icache_address = 16'h0100;
    bus.dcache_read = 1; bus.dcache_address = 16'h0200;
    wait_resp(2, ib + db + 1, 20, "s3_first_resp_seen");
    first = order_q.size() > 0 ? order_q[0] : -1;
`ifdef LINE_MEM_ARBITER_RR_EN
    chk("s3_rr_first_icache", line_t'(first), '0);
    step();
`else
    chk("s3_fixed_first_dcache", line_t'(first), line_t'(1));
    step(); bus.dcache_read = 0;
`endif
    wait_resp(2, ib + db + 2, 20, "s3_second_resp_seen");
    second = order_q.size() > 1 ? order_q[1] : -1;
`ifdef LINE_MEM_ARBITER_RR_EN
    chk("s3_rr_second_dcache", line_t'(second), line_t'(1));
`else
    chk("s3_fixed_second_icache", line_t'(second), '0);
`endif
    step(); bus.icache_read = 0; bus.dcache_read = 0;
    repeat (3) step();
    chk("s3_icache_once", line_t'(i_cnt - ib), line_t'(1));
    chk("s3_dcache_once", line_t'(d_cnt - db), line_t'(1));
    chk("s3_icache_data", i_rdata, LI);
    chk("s3_dcache_data", d_rdata, LD);

    // address change mid-BUSY is ignored; stray pmem_resp in IDLE
    mem_lat = 6; ib = i_cnt; db = d_cnt;
    bus.dcache_read = 1; bus.dcache_address = 16'h0200;
    step(); step(); step();
    bus.dcache_address = 16'h0300;
    @(negedge clk);
    chk("s4_addr_held", line_t'(bus.pmem_address), line_t'(16'h0200));
    wait_resp(1, db + 1, 20, "s4_resp_seen");
    chk("s4_addr_at_resp", line_t'(bus.pmem_address), line_t'(16'h0200));
    chk("s4_data", d_rdata, LD);
    step(); bus.dcache_read = 0; bus.dcache_address = '0;
    repeat (3) step();
    stray_resp = 1'b1;
    step(); stray_resp = 1'b0;
    repeat (2) step();
    chk("s4_stray_no_dresp", line_t'(d_cnt - db), line_t'(1));
    chk("s4_stray_no_iresp", line_t'(i_cnt - ib), '0);

    // reset in the middle of a transaction
    mem_lat = 20; ib = i_cnt; db = d_cnt;
    bus.icache_read = 1; bus.icache_address = 16'h0040;
    repeat (4) step();
    @(negedge clk);
    chk1("s5_busy_before_reset", bus.pmem_read, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("s5_async_strobes_low", line_t'({bus.pmem_read, bus.pmem_write}), '0);
    bus.icache_read = 0;
    step(); step();
    rst = 1'b0;
    repeat (2) step();
    chk("s5_no_resp_after_abort", line_t'((i_cnt - ib) + (d_cnt - db)), '0);
    mem_lat = 2;
    bus.dcache_read = 1; bus.dcache_address = 16'h0040;
    @(negedge clk); @(negedge clk);
    chk1("s5_new_req_strobe", bus.pmem_read, 1'b1);
    wait_resp(1, db + 1, 20, "s5_new_resp_seen");
    chk("s5_new_data", d_rdata, LX);
    step(); bus.dcache_read = 0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
